// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Purpose : Shared definitions for the load/store unit: funct3 size codes,
//           the sequencer state encoding and the big-endian lane helpers.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // funct3 size encodings
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCESS   = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP_ERR = 3'd4
  } lsuState_t;

  // Big-endian byte lane: lane 0 is the most significant byte.
  function automatic logic [7:0] laneByte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  // Big-endian half lane: addr[1]=0 selects the upper half.
  function automatic logic [15:0] laneHalf(input logic [31:0] word, input logic laneHi);
    return laneHi ? word[15:0] : word[31:16];
  endfunction

  // Bit position of the least significant bit of a byte lane.
  function automatic logic [4:0] laneShift(input logic [1:0] lane);
    return {~lane, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Purpose : Combinational data alignment for the load/store unit.
//           Extracts and sign/zero-extends a load lane from a memory word and
//           merges sub-word store data into a memory word (big-endian lanes).
// Ports   : i_size      funct3 of the latched request
//           i_addrLo    byte address bits [1:0]
//           i_rdata     word read from memory
//           i_wdata     store data (only the low half-word can be merged)
//           o_loadData  extended load result
//           o_mergeData read word with the store lane replaced
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addrLo,
  input  logic [31:0] i_rdata,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_loadData,
  output logic [31:0] o_mergeData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_byteShift;
  logic [4:0]  w_halfShift;

  always_comb begin
    w_byte      = laneByte(i_rdata, i_addrLo);
    w_half      = laneHalf(i_rdata, i_addrLo[1]);
    w_byteShift = laneShift(i_addrLo);
    w_halfShift = {~i_addrLo[1], 4'b0000};

    case (i_size)
      SZ_B:    o_loadData = {{24{w_byte[7]}}, w_byte};
      SZ_BU:   o_loadData = {24'h000000, w_byte};
      SZ_H:    o_loadData = {{16{w_half[15]}}, w_half};
      SZ_HU:   o_loadData = {16'h0000, w_half};
      default: o_loadData = i_rdata;
    endcase

    // Clear the target lane, then OR in the new data shifted into place.
    case (i_size[1:0])
      2'b00:   o_mergeData = (i_rdata & ~(32'h0000_00FF << w_byteShift))
                           | ({24'h000000, i_wdata[7:0]} << w_byteShift);
      2'b01:   o_mergeData = (i_rdata & ~(32'h0000_FFFF << w_halfShift))
                           | ({16'h0000, i_wdata} << w_halfShift);
      default: o_mergeData = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Purpose : MEM-stage load/store sequencer in front of a word-only memory.
//           One request at a time; sub-word stores are read-modify-write.
//           Loads are lane-extracted and extended; bad accesses are flagged.
// Ports   : clk, rst_n (synchronous, active-low)
//           req_*   request handshake and payload (req_ready high only in IDLE)
//           resp_*  one-cycle completion pulse with data and error flag
//           mem_*   word-aligned memory strobes, address, write data, read data
//           stat_*  load/store/error counters
// Config  : LSU_STATS_EN - when defined, stat_* are saturating counters;
//           otherwise they are tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_size,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] stat_loads,
  output logic [CNT_W-1:0] stat_stores,
  output logic [CNT_W-1:0] stat_errs
);

  localparam logic [31:0] c_ADDR_LIMIT = 32'(MEM_WORDS) << 2;

  lsuState_t   r_state;
  logic        r_write;
  logic [2:0]  r_size;
  logic [1:0]  r_addrLo;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic        r_respValid;
  logic [31:0] r_respRdata;
  logic        r_respErr;

  logic        w_sizeLegal;
  logic        w_misaligned;
  logic        w_outOfRange;
  logic        w_reqError;
  logic        w_isWordStore;
  logic [31:0] w_loadData;
  logic [31:0] w_mergeData;

  // Request legality check on the incoming (not yet latched) request.
  always_comb begin
    w_sizeLegal  = 1'b1;
    w_misaligned = 1'b0;
    case (req_size)
      SZ_B, SZ_BU: w_misaligned = 1'b0;
      SZ_H, SZ_HU: w_misaligned = req_addr[0];
      SZ_W:        w_misaligned = |req_addr[1:0];
      default:     w_sizeLegal  = 1'b0;
    endcase
    w_outOfRange = (req_addr >= c_ADDR_LIMIT);
    w_reqError   = !w_sizeLegal || w_misaligned || w_outOfRange;
  end

  assign w_isWordStore = r_write && (r_size == SZ_W);

  lsu_align u_align (
    .i_size      (r_size),
    .i_addrLo    (r_addrLo),
    .i_rdata     (mem_rdata),
    .i_wdata     (r_memWdata[15:0]),
    .o_loadData  (w_loadData),
    .o_mergeData (w_mergeData)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_size      <= SZ_B;
      r_addrLo    <= 2'b00;
      r_memAddr   <= 32'h0;
      r_memWdata  <= 32'h0;
      r_respValid <= 1'b0;
      r_respRdata <= 32'h0;
      r_respErr   <= 1'b0;
    end else begin
      r_respValid <= 1'b0;
      r_respErr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_addrLo   <= req_addr[1:0];
            r_memAddr  <= {req_addr[31:2], 2'b00};
            // Raw store data; a sub-word store overwrites this with the merged word.
            r_memWdata <= req_wdata;
            r_state    <= w_reqError ? ST_RESP_ERR : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_isWordStore) begin
            r_respValid <= 1'b1;
            r_respRdata <= 32'h0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (r_write) begin
            r_memWdata <= w_mergeData;
            r_state    <= ST_WRITE;
          end else begin
            r_respValid <= 1'b1;
            r_respRdata <= w_loadData;
            r_state     <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          r_respValid <= 1'b1;
          r_respRdata <= 32'h0;
          r_state     <= ST_IDLE;
        end
        ST_RESP_ERR: begin
          r_respValid <= 1'b1;
          r_respErr   <= 1'b1;
          r_respRdata <= 32'h0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes come straight from registered state, never from the request inputs.
  assign req_ready  = (r_state == ST_IDLE);
  assign mem_read   = (r_state == ST_ACCESS) && !w_isWordStore;
  assign mem_write  = (r_state == ST_WRITE) || ((r_state == ST_ACCESS) && w_isWordStore);
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;
  assign resp_valid = r_respValid;
  assign resp_rdata = r_respRdata;
  assign resp_err   = r_respErr;

`ifdef LSU_STATS_EN
  logic [CNT_W-1:0] r_statLoads;
  logic [CNT_W-1:0] r_statStores;
  logic [CNT_W-1:0] r_statErrs;

  // r_write still describes the completing request on the resp_valid cycle,
  // even if a new request is latched on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_statLoads  <= '0;
      r_statStores <= '0;
      r_statErrs   <= '0;
    end else if (r_respValid) begin
      if (r_respErr) begin
        if (!(&r_statErrs)) r_statErrs <= r_statErrs + 1'b1;
      end else if (r_write) begin
        if (!(&r_statStores)) r_statStores <= r_statStores + 1'b1;
      end else begin
        if (!(&r_statLoads)) r_statLoads <= r_statLoads + 1'b1;
      end
    end
  end

  assign stat_loads  = r_statLoads;
  assign stat_stores = r_statStores;
  assign stat_errs   = r_statErrs;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_errs   = '0;
`endif

endmodule
`default_nettype wire
